// File: rtl/dac_top_level_schematic.sv
// Real-number model of a segmented current-steering DAC core: 17 unary MSB cells plus a
// 7-bit binary LSB segment, differential voltage outputs, calibration current and test bus.
module dac_top_level_schematic #(
  parameter int unsigned NTHERM  = 17,
  parameter int unsigned NBIN    = 7,
  parameter int unsigned NATB    = 10,
  parameter int unsigned CODE_FS = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1,
  parameter real         ICAL_GM = 1.0e-4
) (
  input  logic              clkin,
  input  logic              pdb,
  input  logic              clkinb,
  input  logic [0:NBIN-1]   datainbin,
  input  logic [0:NBIN-1]   datainbinb,
  input  logic [0:NTHERM-1] dataintherm,
  input  logic [0:NTHERM-1] datainthermb,
  input  logic [0:NATB-1]   atb_ena,
  input  real               dataical,
  input  real               vddana_0p8,
  input  real               vddana_1p8,
  input  real               vssana,
  output real               Vout,
  output real               Voutb,
  output real               Ical,
  output real               atb [0:NATB-1]
);

  localparam int unsigned CW = $clog2(CODE_FS + 1);

  logic [0:NBIN-1]   w_bin;
  logic [0:NTHERM-1] w_therm;
  logic              w_mismatch;
  logic [CW-1:0]     w_code_next;
  logic              w_on;
  logic              w_unused_clkinb;
  real               w_code_frac;
  real               w_ical;

  logic [CW-1:0]     r_code;
  logic              r_mismatch;

  // The complement clock carries no information in this model.
  assign w_unused_clkinb = clkinb;

  // Unknown data bits count as 0; they also raise the mismatch flag below.
  for (genvar g = 0; g < NBIN; g++) begin : g_bin
    assign w_bin[g] = (datainbin[g] === 1'b1);
  end

  for (genvar g = 0; g < NTHERM; g++) begin : g_therm
    assign w_therm[g] = (dataintherm[g] === 1'b1);
  end

  // A true/complement pair that agrees (or is unknown) marks the sample as inconsistent.
  assign w_mismatch = (|(datainbin ~^ datainbinb)) || (|(dataintherm ~^ datainthermb)) ||
                      $isunknown({datainbin, datainbinb, dataintherm, datainthermb});

  // Unary cells are equal weight, so only the number of set cells matters.
  assign w_code_next = CW'(CW'($countones(w_therm)) << NBIN) + CW'(w_bin);

  always_ff @(posedge clkin or negedge pdb) begin
    if (!pdb) begin
      r_code     <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_code     <= w_code_next;
      r_mismatch <= w_mismatch;
    end
  end

  // Brown-out on either rail forces the power-down output state; the code is retained.
  assign w_on        = pdb && (vddana_1p8 >= 1.6) && (vddana_0p8 >= 0.7);
  assign w_code_frac = real'(r_code) / real'(CODE_FS);
  assign w_ical      = ICAL_GM * ((dataical > 0.0) ? dataical : 0.0);

  assign Vout  = w_on ? vssana + vddana_0p8 * w_code_frac         : vssana;
  assign Voutb = w_on ? vssana + vddana_0p8 * (1.0 - w_code_frac) : vssana;
  assign Ical  = w_on ? w_ical : 0.0;

  assign atb[0] = (w_on && atb_ena[0]) ? Vout                       : 0.0;
  assign atb[1] = (w_on && atb_ena[1]) ? Voutb                      : 0.0;
  assign atb[2] = (w_on && atb_ena[2]) ? (Vout + Voutb) / 2.0       : 0.0;
  assign atb[3] = (w_on && atb_ena[3]) ? vddana_0p8                 : 0.0;
  assign atb[4] = (w_on && atb_ena[4]) ? vddana_1p8                 : 0.0;
  assign atb[5] = (w_on && atb_ena[5]) ? vssana                     : 0.0;
  assign atb[6] = (w_on && atb_ena[6]) ? dataical                   : 0.0;
  assign atb[7] = (w_on && atb_ena[7]) ? Ical * 1.0e4               : 0.0;
  assign atb[8] = (w_on && atb_ena[8]) ? w_code_frac                : 0.0;
  assign atb[9] = (w_on && atb_ena[9]) ? (r_mismatch ? 1.0 : 0.0)   : 0.0;

endmodule

// File: tb/tb_dac_top_level_schematic.sv
// Scoreboard bench for dac_top_level_schematic: directed vectors push expected values,
// a monitor process pops and compares them against the DUT outputs.
module tb_dac_top_level_schematic;

  localparam int SIG_VOUT  = 10;
  localparam int SIG_VOUTB = 11;
  localparam int SIG_ICAL  = 12;

  typedef struct {
    string name;
    int    sig;
    real   exp;
    real   tol;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event ev_check;

  logic        clk;
  logic        pdb;
  logic        clkinb;
  logic [0:6]  bin, binb;
  logic [0:16] th, thb;
  logic [0:9]  ena;
  real         dataical, v08, v18, vss;
  real         vout, voutb, ical;
  real         atb [0:9];

  assign clkinb = ~clk;

  dac_top_level_schematic dut (
    .clkin        (clk),
    .pdb          (pdb),
    .clkinb       (clkinb),
    .datainbin    (bin),
    .datainbinb   (binb),
    .dataintherm  (th),
    .datainthermb (thb),
    .atb_ena      (ena),
    .dataical     (dataical),
    .vddana_0p8   (v08),
    .vddana_1p8   (v18),
    .vssana       (vss),
    .Vout         (vout),
    .Voutb        (voutb),
    .Ical         (ical),
    .atb          (atb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real actual(int s);
    if (s >= 0 && s < 10) return atb[s];
    case (s)
      SIG_VOUT:  return vout;
      SIG_VOUTB: return voutb;
      SIG_ICAL:  return ical;
      default:   return -99.0;
    endcase
  endfunction

  // Monitor: on each observation strobe, drain the scoreboard against live outputs.
  always begin
    exp_t e;
    real  act;
    @(ev_check);
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = actual(e.sig);
      checks++;
      if ((act > e.exp + e.tol) || (act < e.exp - e.tol)) begin
        errors++;
        $display("FAIL %s: got %0.9f expected %0.9f (tol %g)", e.name, act, e.exp, e.tol);
      end
    end
  end

  task automatic expect_v(string n, int s, real v, real t = 1.0e-6);
    exp_t e;
    e = '{n, s, v, t};
    q.push_back(e);
  endtask

  task automatic check_now();
    #1;
    -> ev_check;
    for (int i = 0; i < 10 && q.size() > 0; i++) #1;
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
      $fatal(1, "monitor stalled");
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_code(input logic [0:16] t, input logic [0:6] b);
    th   = t;
    thb  = ~t;
    bin  = b;
    binb = ~b;
  endtask

  initial begin
    pdb      = 1'b0;
    ena      = '1;
    dataical = 0.3;
    v08      = 0.8;
    v18      = 1.8;
    vss      = 0.0;
    set_code(17'h0F0F0, 7'h55);
    #1;

    // Power-down with live data and clocking
    repeat (3) clk_step();
    expect_v("pd_vout", SIG_VOUT, 0.0);
    expect_v("pd_voutb", SIG_VOUTB, 0.0);
    expect_v("pd_ical", SIG_ICAL, 0.0, 1.0e-12);
    for (int i = 0; i < 10; i++) expect_v($sformatf("pd_atb%0d", i), i, 0.0);
    check_now();

    // Release, zero code
    set_code('0, '0);
    pdb = 1'b1;
    clk_step();
    expect_v("zero_vout", SIG_VOUT, 0.0);
    expect_v("zero_voutb", SIG_VOUTB, 0.8);
    expect_v("zero_atb2", 2, 0.4);
    expect_v("zero_atb3", 3, 0.8);
    expect_v("zero_atb4", 4, 1.8);
    expect_v("zero_atb5", 5, 0.0);
    check_now();

    // Full scale
    set_code('1, '1);
    clk_step();
    expect_v("fs_vout", SIG_VOUT, 0.8);
    expect_v("fs_voutb", SIG_VOUTB, 0.0);
    expect_v("fs_atb0", 0, 0.8);
    expect_v("fs_atb8", 8, 1.0);
    expect_v("fs_atb9", 9, 0.0);
    check_now();

    // Mid code 1024
    set_code(17'h1FE00, 7'h00);
    clk_step();
    expect_v("mid_vout", SIG_VOUT, 0.35571, 1.0e-5);
    expect_v("mid_voutb", SIG_VOUTB, 0.44429, 1.0e-5);
    expect_v("mid_atb2", 2, 0.4);
    expect_v("mid_atb8", 8, 0.4446374, 1.0e-6);
    check_now();

    // Non-contiguous thermometer: 9 cells -> code 1152
    set_code(17'h15555, 7'h00);
    clk_step();
    expect_v("noncontig_vout", SIG_VOUT, 0.4001737, 1.0e-6);
    check_now();

    // LSB step only at the clock edge
    set_code('0, '0);
    clk_step();
    expect_v("lsb_base_vout", SIG_VOUT, 0.0, 1.0e-9);
    check_now();
    set_code('0, 7'd1);
    expect_v("lsb_before_edge", SIG_VOUT, 0.0, 1.0e-9);
    check_now();
    clk_step();
    expect_v("lsb_after_edge", SIG_VOUT, 0.000347373, 1.0e-8);
    expect_v("lsb_atb8", 8, 0.0004342162, 1.0e-9);
    check_now();

    // Binary pair mismatch plus calibration path
    bin      = 7'd8;
    binb     = 7'h7F;
    th       = '0;
    thb      = '1;
    dataical = 0.5;
    clk_step();
    expect_v("mm_atb9", 9, 1.0);
    expect_v("mm_ical", SIG_ICAL, 5.0e-5, 1.0e-10);
    expect_v("mm_atb7", 7, 0.5, 1.0e-9);
    expect_v("mm_atb6", 6, 0.5);
    expect_v("mm_vout", SIG_VOUT, 0.002778984, 1.0e-8);
    check_now();

    dataical = -0.2;
    expect_v("ical_clamp", SIG_ICAL, 0.0, 1.0e-12);
    expect_v("ical_clamp_atb7", 7, 0.0);
    check_now();

    binb = ~bin;
    clk_step();
    expect_v("mm_clear_atb9", 9, 0.0);
    check_now();

    // Thermometer pair mismatch (both rails 0)
    thb = '0;
    clk_step();
    expect_v("mm_therm_atb9", 9, 1.0);
    expect_v("mm_therm_vout", SIG_VOUT, 0.002778984, 1.0e-8);
    check_now();

    // Supply gate with retained code
    set_code('1, '1);
    dataical = 0.5;
    clk_step();
    expect_v("sg_base_vout", SIG_VOUT, 0.8);
    check_now();
    v08 = 0.6;
    expect_v("sg_low08_vout", SIG_VOUT, 0.0);
    expect_v("sg_low08_voutb", SIG_VOUTB, 0.0);
    expect_v("sg_low08_ical", SIG_ICAL, 0.0, 1.0e-12);
    expect_v("sg_low08_atb8", 8, 0.0);
    check_now();
    v08 = 0.8;
    expect_v("sg_restore_vout", SIG_VOUT, 0.8);
    expect_v("sg_restore_ical", SIG_ICAL, 5.0e-5, 1.0e-10);
    check_now();
    v18 = 1.5;
    expect_v("sg_low18_vout", SIG_VOUT, 0.0);
    check_now();
    v18 = 1.8;
    v08 = 0.7;
    expect_v("sg_edge07_vout", SIG_VOUT, 0.7);
    check_now();
    v08 = 0.8;

    // Asynchronous power-down mid-cycle clears the code
    pdb = 1'b0;
    expect_v("async_pd_vout", SIG_VOUT, 0.0);
    expect_v("async_pd_atb3", 3, 0.0);
    check_now();
    pdb = 1'b1;
    expect_v("async_rel_vout", SIG_VOUT, 0.0);
    expect_v("async_rel_voutb", SIG_VOUTB, 0.8);
    check_now();
    clk_step();
    expect_v("async_first_edge", SIG_VOUT, 0.8);
    check_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_top_level_schematic.md
Name:
dac_top_level_schematic

Overview:
- Behavioural real-number model of a segmented current-steering DAC core with differential voltage outputs.
- Input code is split into a 17-cell unary (thermometer) MSB segment and a 7-bit binary LSB segment; each segment has true and complement inputs.
- Sits at the analog top of the DAC macro: receives clock, power-down, supplies and calibration input; drives Vout/Voutb, a calibration current Ical and a 10-line analog test bus (atb).

Parameters:
- NTHERM, 17, number of unary cells, each worth 2^NBIN LSB.
- NBIN, 7, binary LSB segment width.
- NATB, 10, analog test bus lines.
- CODE_FS, 2303, full-scale code = NTHERM*2^NBIN + 2^NBIN - 1.
- ICAL_GM, 1.0e-4, Ical transconductance in A/V.

Ports:
- clkin  in  1  sampling clock, rising edge active.
- pdb  in  1  asynchronous active-low reset / power-down.
- clkinb  in  1  complement clock; no functional use; tied off in the model.
- datainbin  in  [0:6]  binary LSBs, bit 0 = MSB (weight 64), bit 6 weight 1.
- datainbinb  in  [0:6]  complement of datainbin.
- dataintherm  in  [0:16]  unary cells, each weight 128.
- datainthermb  in  [0:16]  complement of dataintherm.
- atb_ena  in  [0:9]  per-line test-bus enable.
- dataical  in  real  calibration control voltage.
- vddana_0p8  in  real  0.8 V analog supply; sets output full scale.
- vddana_1p8  in  real  1.8 V analog supply.
- vssana  in  real  analog ground reference.
- Vout  out  real  positive output voltage.
- Voutb  out  real  negative output voltage.
- Ical  out  real  calibration current in A.
- atb  out  real[10]  analog test bus.

Behaviour:
- Reset and power-down:
  - pdb=0 asynchronously clears code register to 0 and clears the mismatch flag.
  - While pdb=0, outputs are forced: Vout=Voutb=vssana, Ical=0.0, every atb[i]=0.0.
- Sampling:
  - On each rising clkin with pdb=1, register code = 128*popcount(dataintherm) + unsigned(datainbin).
  - Register mismatch = 1 if any bit of datainbin equals the same bit of datainbinb, or any bit of dataintherm equals the same bit of datainthermb.
  - Latency: outputs reflect the new code immediately after the sampling edge. Input changes between edges have no effect.
- Thermometer segment: cells have equal weight, so popcount is used. Non-contiguous patterns are legal and are not corrected.
- Complement inputs: only the true inputs set the code. The complement inputs only drive the mismatch flag.
- Supply gate: if vddana_1p8 < 1.6 or vddana_0p8 < 0.7, outputs behave as in power-down. The code register keeps its value.
- Output transfer, when powered:
  - Vout = vssana + vddana_0p8*code/CODE_FS.
  - Voutb = vssana + vddana_0p8*(CODE_FS-code)/CODE_FS.
  - Vout + Voutb = 2*vssana + vddana_0p8 for every code.
- Ical = ICAL_GM*max(dataical, 0.0). This path is combinational and gated only by pdb and the supply gate.
- Test bus: atb[i] = monitor value when atb_ena[i]=1, else 0.0. Combinational. Multiple lines may be enabled at once.
  - atb[0] Vout
  - atb[1] Voutb
  - atb[2] (Vout+Voutb)/2
  - atb[3] vddana_0p8
  - atb[4] vddana_1p8
  - atb[5] vssana
  - atb[6] dataical
  - atb[7] Ical*1e4 (volts)
  - atb[8] code/CODE_FS
  - atb[9] 1.0 if mismatch else 0.0
- X/Z on any data bit: that bit is treated as 0 and mismatch is set.
- pdb rising releases reset; the first valid code appears at the next clkin rising edge.

Test Plan:
- Power-down:
  - Stimulus: pdb=0, arbitrary data, clocking.
  - Required: Vout=Voutb=0.0, Ical=0.0, all atb=0.0.
  - Then pdb=1 and one clkin edge with zero code: Vout=0.0, Voutb=0.8.
- Full scale:
  - Stimulus: dataintherm all 1, datainbin=7'b1111111, complements correct.
  - Required after one edge: Vout=0.8, Voutb=0.0, atb_ena[8]=1 gives atb[8]=1.0.
- Mid code:
  - Stimulus: therm bits 0..7 set, bin=0.
  - Required: code 1024, Vout=0.35571 (±1e-5), Voutb=0.44429, atb[2]=0.4.
- LSB step:
  - Stimulus: bin goes 0 -> 7'b0000001 with therm all 0.
  - Required: Vout changes by 0.8/2303 = 347.4 µV only at the next rising clkin, not before.
- Mismatch and calibration:
  - Stimulus: datainbinb[3]=datainbin[3], atb_ena[9]=1, dataical=0.5, atb_ena[7]=1.
  - Required: atb[9]=1.0, Ical=5e-5, atb[7]=0.5. Code still follows the true inputs.
- Supply gate:
  - Stimulus: vddana_0p8=0.6 with full-scale code.
  - Required: Vout=Voutb=vssana.
  - Restore 0.8: Vout=0.8 with no new clock edge, since the register is retained.
